// File: rtl/crc16_check.sv
// Receive-side CRC-16-CCITT block checker: shifts payload bytes MSB-first through
// a serial LFSR, captures the two trailing CRC bytes and flags match/mismatch.
`timescale 1ns/1ps
module crc16_check #(
   parameter int BLOCK_BYTES = 512
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic        check_done,
   output logic        crc_ok,
   output logic [15:0] crc_calc,
   output logic [15:0] crc_recv
);
   // state | meaning
   // LOAD  | waiting for the next byte (byte_ready high)
   // SHIFT | serialising the latched byte, 8 cycles
   // DONE  | one-cycle result strobe, crc_ok updated
   typedef enum logic [1:0] {LOAD, SHIFT, DONE} state_t;

   localparam int               CW       = $clog2(BLOCK_BYTES + 2);
   localparam logic [CW-1:0]    PAY_CNT  = CW'(BLOCK_BYTES);
   localparam logic [CW-1:0]    LAST_CNT = CW'(BLOCK_BYTES + 1);
   localparam logic [15:0]      POLY     = 16'h1021;

   state_t          r_state;
   logic [7:0]      r_shift;
   logic [2:0]      r_bit_cnt;
   logic [CW-1:0]   r_byte_cnt;
   logic [15:0]     r_crc_calc;
   logic [15:0]     r_crc_recv;
   logic            r_crc_ok;

   logic            w_bit;
   logic            w_payload;
   logic            w_fb;

   assign w_bit     = r_shift[7];
   assign w_payload = (r_byte_cnt < PAY_CNT);
   assign w_fb      = r_crc_calc[15] ^ w_bit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= LOAD;
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_byte_cnt <= '0;
         r_crc_calc <= '0;
         r_crc_recv <= '0;
         r_crc_ok   <= 1'b0;
      end else if (clear) begin
         r_state    <= LOAD;
         r_byte_cnt <= '0;
         r_crc_calc <= '0;
         r_crc_recv <= '0;
      end else begin
         case (r_state)
            LOAD: begin
               if (byte_valid) begin
                  r_shift   <= byte_in;
                  r_bit_cnt <= 3'd7;
                  r_state   <= SHIFT;
                  // previous block's results stay readable until the next block starts
                  if (r_byte_cnt == '0) begin
                     r_crc_calc <= '0;
                     r_crc_recv <= '0;
                  end
               end
            end
            SHIFT: begin
               r_shift   <= {r_shift[6:0], 1'b0};
               r_bit_cnt <= r_bit_cnt - 3'd1;
               if (w_payload)
                  r_crc_calc <= {r_crc_calc[14:0], 1'b0} ^ (w_fb ? POLY : 16'h0000);
               else
                  r_crc_recv <= {r_crc_recv[14:0], w_bit};
               if (r_bit_cnt == 3'd0) begin
                  if (r_byte_cnt == LAST_CNT) begin
                     r_byte_cnt <= '0;
                     r_state    <= DONE;
                  end else begin
                     r_byte_cnt <= r_byte_cnt + 1'b1;
                     r_state    <= LOAD;
                  end
               end
            end
            DONE: begin
               r_crc_ok <= (r_crc_calc == r_crc_recv);
               r_state  <= LOAD;
            end
            default: r_state <= LOAD;
         endcase
      end
   end

   assign byte_ready = (r_state == LOAD);
   assign check_done = (r_state == DONE);
   assign crc_ok     = r_crc_ok;
   assign crc_calc   = r_crc_calc;
   assign crc_recv   = r_crc_recv;

endmodule
